// File: rtl/wb_buffer_if.sv
// Bundle of write-back producer, register-file write and forwarding lookup signals
// for wb_buffer; clk/rst_n stay as plain ports on the modules.
interface wb_buffer_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_rd;
    logic [DATA_W-1:0] in_data;
    logic              regwrite;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] write_data;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic              fwd1_hit;
    logic              fwd2_hit;
    logic [DATA_W-1:0] fwd1_data;
    logic [DATA_W-1:0] fwd2_data;
    logic [CNT_W-1:0]  count;

    // Producer / lookup side (drives entries and lookup indices)
    modport master (
        output in_valid, in_rd, in_data, rs1, rs2,
        input  in_ready, regwrite, rd, write_data,
        input  fwd1_hit, fwd2_hit, fwd1_data, fwd2_data, count
    );

    // Buffer side
    modport slave (
        input  in_valid, in_rd, in_data, rs1, rs2,
        output in_ready, regwrite, rd, write_data,
        output fwd1_hit, fwd2_hit, fwd1_data, fwd2_data, count
    );
endinterface

// File: rtl/wb_buffer.sv
// Write-back buffer: circular FIFO draining one entry per cycle into the register file,
// with optional forwarding lookup compiled in by defining WB_FWD_EN.
module wb_buffer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    wb_buffer_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  head_r;
    logic [PTR_W-1:0]  tail_r;
    logic [CNT_W-1:0]  count_r;
    logic [ADDR_W-1:0] rd_mem_r   [DEPTH];
    logic [DATA_W-1:0] data_mem_r [DEPTH];

    logic in_ready_s;
    logic push_s;
    logic pop_s;

    // Handshake qualification; index 0 is accepted but never stored
    always_comb begin
        in_ready_s = (count_r < CNT_W'(DEPTH));
        push_s     = bus.in_valid && in_ready_s && (bus.in_rd != '0);
        pop_s      = (count_r != '0);
    end

    // Pointer and occupancy state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            if (push_s) begin
                tail_r <= tail_r + PTR_W'(1);
            end
            if (pop_s) begin
                head_r <= head_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage, written at the tail on accepted pushes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                rd_mem_r[i]   <= '0;
                data_mem_r[i] <= '0;
            end
        end else if (push_s) begin
            rd_mem_r[tail_r]   <= bus.in_rd;
            data_mem_r[tail_r] <= bus.in_data;
        end else begin
            rd_mem_r[tail_r]   <= rd_mem_r[tail_r];
            data_mem_r[tail_r] <= data_mem_r[tail_r];
        end
    end

    // Register-file write port: head entry while non-empty, zeros otherwise
    always_comb begin
        bus.in_ready = in_ready_s;
        bus.count    = count_r;
        bus.regwrite = pop_s;
        if (pop_s) begin
            bus.rd         = rd_mem_r[head_r];
            bus.write_data = data_mem_r[head_r];
        end else begin
            bus.rd         = '0;
            bus.write_data = '0;
        end
    end

`ifdef WB_FWD_EN
    // Forwarding: walk head to tail so the youngest matching entry wins
    always_comb begin
        bus.fwd1_hit  = 1'b0;
        bus.fwd2_hit  = 1'b0;
        bus.fwd1_data = '0;
        bus.fwd2_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < count_r) begin
                if ((bus.rs1 != '0) && (rd_mem_r[head_r + PTR_W'(i)] == bus.rs1)) begin
                    bus.fwd1_hit  = 1'b1;
                    bus.fwd1_data = data_mem_r[head_r + PTR_W'(i)];
                end else begin
                    bus.fwd1_hit  = bus.fwd1_hit;
                end
                if ((bus.rs2 != '0) && (rd_mem_r[head_r + PTR_W'(i)] == bus.rs2)) begin
                    bus.fwd2_hit  = 1'b1;
                    bus.fwd2_data = data_mem_r[head_r + PTR_W'(i)];
                end else begin
                    bus.fwd2_hit  = bus.fwd2_hit;
                end
            end else begin
                bus.fwd1_hit = bus.fwd1_hit;
            end
        end
    end
`else
    logic unused_fwd_s;

    // Forwarding compiled out: outputs held at zero, lookup indices ignored
    always_comb begin
        bus.fwd1_hit  = 1'b0;
        bus.fwd2_hit  = 1'b0;
        bus.fwd1_data = '0;
        bus.fwd2_data = '0;
        unused_fwd_s  = ^{bus.rs1, bus.rs2};
    end
`endif

endmodule
